// File: rtl/taus_urng.sv
// Uniform random source for the Box-Muller Gaussian noise generator: two taus88
// combined-Tausworthe generators packed into a 48-bit U0 and a 16-bit U1 per step.
module taus_urng #(
  parameter int unsigned WARMUP_CYCLES = 16,
  parameter logic [31:0] SEED_A1 = 32'h12345678,
  parameter logic [31:0] SEED_A2 = 32'h9ABCDEF0,
  parameter logic [31:0] SEED_A3 = 32'h0F1E2D3C,
  parameter logic [31:0] SEED_B1 = 32'hDEADBEEF,
  parameter logic [31:0] SEED_B2 = 32'hCAFEF00D,
  parameter logic [31:0] SEED_B3 = 32'h8BADF00D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_we,
  input  logic [31:0] seed_data,
  input  logic        start,
  output logic        busy,
  output logic [47:0] u0,
  output logic [15:0] u1,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN} state_t;

  // Slot order A1,A2,A3,B1,B2,B3; minimum legal value per component.
  localparam logic [31:0] SEED_DEF [6] = '{SEED_A1, SEED_A2, SEED_A3,
                                           SEED_B1, SEED_B2, SEED_B3};
  localparam logic [31:0] SEED_MIN [6] = '{32'd2, 32'd8, 32'd16,
                                           32'd2, 32'd8, 32'd16};
  localparam logic [7:0]  CNT_LAST = 8'(WARMUP_CYCLES - 1);

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [31:0] gen_q [6];
  logic [31:0] gen_d [6];
  logic [31:0] gen_nx [6];
  logic [47:0] u0_q, u0_d;
  logic [15:0] u1_q, u1_d;
  logic        valid_q, valid_d;
  logic [31:0] word_a, word_b;
  logic        run_step;

  function automatic logic [31:0] step1(input logic [31:0] s);
    step1 = ((s & 32'hFFFFFFFE) << 12) ^ (((s << 13) ^ s) >> 19);
  endfunction

  function automatic logic [31:0] step2(input logic [31:0] s);
    step2 = ((s & 32'hFFFFFFF8) << 4) ^ (((s << 2) ^ s) >> 25);
  endfunction

  function automatic logic [31:0] step3(input logic [31:0] s);
    step3 = ((s & 32'hFFFFFFF0) << 17) ^ (((s << 3) ^ s) >> 11);
  endfunction

  always_comb begin
    gen_nx[0] = step1(gen_q[0]);
    gen_nx[1] = step2(gen_q[1]);
    gen_nx[2] = step3(gen_q[2]);
    gen_nx[3] = step1(gen_q[3]);
    gen_nx[4] = step2(gen_q[4]);
    gen_nx[5] = step3(gen_q[5]);
    word_a    = gen_nx[0] ^ gen_nx[1] ^ gen_nx[2];
    word_b    = gen_nx[3] ^ gen_nx[4] ^ gen_nx[5];
    run_step  = !valid_q || out_ready;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_WARM;
      S_WARM:  if (cnt_q == CNT_LAST) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Datapath: seed slots, warm-up counter, generator steps and sample register.
  always_comb begin
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    u0_d    = u0_q;
    u1_d    = u1_q;
    valid_d = valid_q;
    for (int i = 0; i < 6; i++) gen_d[i] = gen_q[i];
    case (state_q)
      S_IDLE: begin
        if (seed_we) begin
          // Words too small would lock a component at zero, so they fall back to the default.
          for (int i = 0; i < 6; i++) begin
            if (ptr_q == 3'(i))
              gen_d[i] = (seed_data < SEED_MIN[i]) ? SEED_DEF[i] : seed_data;
          end
          ptr_d = (ptr_q == 3'd5) ? 3'd0 : ptr_q + 3'd1;
        end
        if (start) cnt_d = 8'd0;
      end
      S_WARM: begin
        for (int i = 0; i < 6; i++) gen_d[i] = gen_nx[i];
        cnt_d = cnt_q + 8'd1;
      end
      S_RUN: begin
        if (run_step) begin
          for (int i = 0; i < 6; i++) gen_d[i] = gen_nx[i];
          u0_d    = {word_a, word_b[31:16]};
          u1_d    = word_b[15:0];
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= 8'd0;
      ptr_q   <= 3'd0;
      u0_q    <= 48'd0;
      u1_q    <= 16'd0;
      valid_q <= 1'b0;
      for (int i = 0; i < 6; i++) gen_q[i] <= SEED_DEF[i];
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      u0_q    <= u0_d;
      u1_q    <= u1_d;
      valid_q <= valid_d;
      for (int i = 0; i < 6; i++) gen_q[i] <= gen_d[i];
    end
  end

  assign busy      = busy_q;
  assign u0        = u0_q;
  assign u1        = u1_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_taus_urng.sv
// Bench for taus_urng: taus88 reference model feeding an expected-sample queue,
// seed vectors from a table plus hand-written stall/ignore/reset sequences.
module tb_taus_urng;
  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_we = 1'b0;
  logic [31:0] seed_data = 32'd0;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic        busy, out_valid;
  logic [47:0] u0;
  logic [15:0] u1;

  always #5 clk = ~clk;

  taus_urng #(.WARMUP_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .seed_we(seed_we), .seed_data(seed_data),
    .start(start), .busy(busy), .u0(u0), .u1(u1),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic [31:0] ms [6];

  typedef struct {
    int          nw;
    int          nsamp;
    logic [31:0] wr  [7];
    logic [31:0] eff [6];
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // taus88 reference (C form: b = ((s<<a)^s)>>b; s = ((s&m)<<c)^b).
  function automatic logic [31:0] t1(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 13) ^ s) >> 19;
    return ((s & 32'hFFFFFFFE) << 12) ^ b;
  endfunction
  function automatic logic [31:0] t2(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 2) ^ s) >> 25;
    return ((s & 32'hFFFFFFF8) << 4) ^ b;
  endfunction
  function automatic logic [31:0] t3(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 3) ^ s) >> 11;
    return ((s & 32'hFFFFFFF0) << 17) ^ b;
  endfunction

  task automatic model_step(output logic [31:0] wa, output logic [31:0] wb);
    ms[0] = t1(ms[0]); ms[1] = t2(ms[1]); ms[2] = t3(ms[2]);
    ms[3] = t1(ms[3]); ms[4] = t2(ms[4]); ms[5] = t3(ms[5]);
    wa = ms[0] ^ ms[1] ^ ms[2];
    wb = ms[3] ^ ms[4] ^ ms[5];
  endtask

  // {u0,u1} is exactly {A,B}.
  task automatic model_push(input int n);
    logic [31:0] wa, wb;
    for (int i = 0; i < n; i++) begin
      model_step(wa, wb);
      exp_q.push_back({wa, wb});
    end
  endtask

  task automatic model_warm();
    logic [31:0] wa, wb;
    for (int i = 0; i < W; i++) model_step(wa, wb);
  endtask

  task automatic model_defaults();
    ms = '{32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C,
           32'hDEADBEEF, 32'hCAFEF00D, 32'h8BADF00D};
  endtask

  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_sample", {u0, u1}, 64'd0);
        if ({u0, u1} === 64'd0) begin
          errors++;
          $display("FAIL extra_sample: got %h expected none", {u0, u1});
        end
      end else begin
        e = exp_q.pop_front();
        check("sample", {u0, u1}, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mon_en = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_seed(input logic [31:0] d);
    seed_we = 1'b1;
    seed_data = d;
    tick();
    seed_we = 1'b0;
  endtask

  task automatic start_run();
    int lat;
    start = 1'b1;
    tick();
    start = 1'b0;
    mon_en = 1'b1;
    check("busy_after_start", 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check("first_valid_latency", 64'(lat), 64'(W + 1));
  endtask

  task automatic wait_queue_le(input int lvl, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > lvl && n < budget) begin
      tick();
      n++;
    end
    check("queue_level", 64'(exp_q.size() > lvl), 64'd0);
  endtask

  task automatic drain();
    wait_queue_le(0, 500);
    mon_en = 1'b0;
  endtask

  initial begin
    logic [63:0] hold;

    vecs[0] = '{nw: 0, nsamp: 64, wr: '{default: 32'd0},
                eff: '{32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C,
                       32'hDEADBEEF, 32'hCAFEF00D, 32'h8BADF00D}};
    vecs[1] = '{nw: 6, nsamp: 16,
                wr: '{32'h2, 32'h8, 32'h10, 32'h3, 32'h9, 32'h11, 32'h0},
                eff: '{32'h2, 32'h8, 32'h10, 32'h3, 32'h9, 32'h11}};
    vecs[2] = '{nw: 7, nsamp: 16,
                wr: '{32'h2, 32'h8, 32'h10, 32'h3, 32'h9, 32'h11, 32'h55555555},
                eff: '{32'h55555555, 32'h8, 32'h10, 32'h3, 32'h9, 32'h11}};
    vecs[3] = '{nw: 6, nsamp: 16,
                wr: '{32'h0, 32'h8, 32'h10, 32'h3, 32'h9, 32'h5, 32'h0},
                eff: '{32'h12345678, 32'h8, 32'h10, 32'h3, 32'h9, 32'h8BADF00D}};
    vecs[4] = '{nw: 6, nsamp: 16,
                wr: '{32'h1, 32'h7, 32'hF, 32'h1, 32'h7, 32'hF, 32'h0},
                eff: '{32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C,
                       32'hDEADBEEF, 32'hCAFEF00D, 32'h8BADF00D}};

    do_reset();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_u0u1", {u0, u1}, 64'd0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int k = 0; k < vecs[v].nw; k++) write_seed(vecs[v].wr[k]);
      ms = vecs[v].eff;
      model_warm();
      model_push(vecs[v].nsamp);
      start_run();
      drain();
    end

    // Seed write and start in the same cycle: the write lands, then warm-up.
    do_reset();
    write_seed(32'h2); write_seed(32'h8); write_seed(32'h10);
    write_seed(32'h3); write_seed(32'h9);
    seed_we = 1'b1;
    seed_data = 32'h11;
    start = 1'b1;
    tick();
    seed_we = 1'b0;
    start = 1'b0;
    mon_en = 1'b1;
    ms = '{32'h2, 32'h8, 32'h10, 32'h3, 32'h9, 32'h11};
    model_warm();
    model_push(8);
    drain();

    // Ignored controls in WARM and RUN, then backpressure, then reset mid-RUN.
    do_reset();
    model_defaults();
    model_warm();
    model_push(64);
    start = 1'b1;
    tick();
    start = 1'b0;
    mon_en = 1'b1;
    tick(); tick(); tick();
    seed_we = 1'b1;
    seed_data = 32'h0;
    start = 1'b1;
    tick();
    seed_we = 1'b0;
    start = 1'b0;
    check("busy_warm", 64'(busy), 64'd1);
    wait_queue_le(54, 200);
    seed_we = 1'b1;
    seed_data = 32'hFFFF0000;
    start = 1'b1;
    tick();
    seed_we = 1'b0;
    start = 1'b0;
    check("busy_run", 64'(busy), 64'd1);
    wait_queue_le(40, 200);

    out_ready = 1'b0;
    hold = {u0, u1};
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_hold", {u0, u1}, hold);
      check("stall_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    wait_queue_le(20, 200);

    rst = 1'b1;
    mon_en = 1'b0;
    tick();
    rst = 1'b0;
    check("midrun_valid", 64'(out_valid), 64'd0);
    check("midrun_busy", 64'(busy), 64'd0);
    check("midrun_u0u1", {u0, u1}, 64'd0);
    exp_q.delete();
    model_defaults();
    model_warm();
    model_push(32);
    start_run();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
